mux4_1_rr: RTL
==============

Name: mux4_1_rr

Overview:
- Four-lane to one-lane round-robin multiplexer with valid/ready handshakes on every lane and a registered output stage.
- Each output word carries a 2-bit lane tag, SOUT. SOUT uses the same S encoding as the team's 1-to-4 demultiplexer, so the demux can route each word back to its originating lane.
- Sits ahead of a shared serial or bus link. Multiple producers share one channel through it.

Parameters:
- WIDTH, 8, data width per lane in bits (legal range 1..64).

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous, active-high reset
- DIN  input  4*WIDTH  lane data, packed. Lane k occupies DIN[(4-k)*WIDTH-1 -: WIDTH], so lane 0 is the MSB slice.
- VLD  input  4  lane valid. Lane k is VLD[3-k].
- RDY  output  4  lane ready. Lane k is RDY[3-k]. Combinational.
- DOUT  output  WIDTH  output data, registered.
- SOUT  output  2  lane tag of DOUT, registered. Value k means lane k (00 is the MSB lane, as in the demux S input).
- VOUT  output  1  output valid, registered.
- RIN  input  1  downstream ready.

Behaviour:
- Reset, asynchronous on RST high: DOUT=0, SOUT=2'b00, VOUT=0, round-robin pointer PTR=0, output state EMPTY. RDY is forced to 0 while RST is high.
- Handshake rules:
  - A transfer occurs on any edge where valid and ready are both 1.
  - Producers hold VLD/DIN stable until accepted. VLD must not depend on RDY.
  - Downstream may drop RIN at any time.
- Output state machine, EMPTY/FULL (FULL is equivalent to VOUT=1):
  - load_en = (state==EMPTY) | RIN.
  - EMPTY -> FULL when any VLD=1.
  - FULL -> FULL when RIN=1 and any VLD=1 (back-to-back load).
  - FULL -> EMPTY when RIN=1 and no VLD.
  - FULL holds when RIN=0. DOUT and SOUT stay stable and all RDY=0.
- Arbitration (combinational):
  - Search lanes PTR, PTR+1, ... (mod 4). The first lane with VLD=1 is granted.
  - RDY for the granted lane = load_en. All other RDY=0. At most one RDY is high per cycle.
- On transfer from lane g: DOUT<=DIN lane g, SOUT<=g, VOUT<=1, PTR<=(g+1) mod 4. PTR wraps 3 -> 0.
- With no VLD, PTR is unchanged.
- Latency: 1 cycle from lane accept to VOUT. Sustained throughput is 1 word/cycle when RIN stays high.
- Fairness: with all four lanes continuously valid and RIN=1, the grant order is 0,1,2,3,0,...
- Simultaneous events: the output word is consumed (RIN=1) and a new lane is accepted in the same cycle. No bubble is inserted.
- Reset mid-operation discards the held word. No lane sees a handshake on the reset edge.

Optional Feature:
- Macro MUX4_1_RR_PRIO_EN.
- Defined: fixed priority. Lane 0 is highest and lane 3 lowest. PTR is removed, and its reset behaviour is not applicable.
- Undefined (default): round-robin as described above. Handshake, latency and output timing are identical in both builds.

Decomposition:
- Package mux4_1_pkg holds:
  - LANES=4, SEL_W=2.
  - typedef sel_t (logic [SEL_W-1:0]).
  - Function lane_slice index helper, to keep DIN/VLD/RDY lane k mapped to MSB-first positions.
- One sub-module, rr_arb4. Inputs: req[3:0], ptr (sel_t). Outputs: gnt one-hot, gnt_idx (sel_t), any. Purely combinational. The priority variant is selected inside it by the macro.
- mux4_1_rr holds PTR, the output register and the EMPTY/FULL logic.

Test Plan:
- Reset: assert RST mid-stream with VOUT=1 -> DOUT=0, SOUT=0, VOUT=0, RDY=0 immediately (asynchronous). After release, lane 0 is first in search order.
- Single lane: only lane 2 valid, DIN lane2=8'hA5, RIN=1 -> RDY lane 2 pulses. The next cycle shows DOUT=8'hA5, SOUT=2'b10, VOUT=1. PTR becomes 3.
- Fairness: all VLD=1 with distinct data, RIN=1 for 8 cycles -> SOUT sequence 0,1,2,3,0,1,2,3, one word per cycle, no bubbles. With MUX4_1_RR_PRIO_EN the sequence is all 0.
- Backpressure: VOUT=1, RIN=0 for 5 cycles with lanes valid -> DOUT/SOUT stable, RDY=0. When RIN rises, the next grant goes to the lane following the held word's SOUT.
- Wrap and skip: PTR=3, VLD only lanes 1 and 3 -> lane 3 granted, then lane 1, then PTR=2.
- Loopback: feed DOUT/SOUT into the 1-to-4 demux (WIDTH=1) -> each bit appears on Y[3-k] for its source lane k.

Source files
------------

// File: rtl/mux4_1_pkg.sv
// mux4_1_pkg: shared lane count, tag type, output state and MSB-first lane index helper
package mux4_1_pkg;
    localparam int LANES = 4;
    localparam int SEL_W = 2;
    typedef logic [SEL_W-1:0] sel_t;
    typedef enum logic {EMPTY, FULL} state_t;
    function automatic sel_t lane_slice(sel_t k);
        return sel_t'(LANES - 1) - k;
    endfunction
endpackage

// File: rtl/rr_arb4.sv
// rr_arb4: 4-way round-robin arbiter from ptr; MUX4_1_RR_PRIO_EN selects fixed priority with lane 0 highest
module rr_arb4
    import mux4_1_pkg::*;
(
    input  logic [LANES-1:0] req,
    input  sel_t             ptr,
    output logic [LANES-1:0] gnt,
    output sel_t             gnt_idx,
    output logic             any
);
    sel_t base;
`ifdef MUX4_1_RR_PRIO_EN
    assign base = '0;
`else
    assign base = ptr;
`endif
    always_comb begin
        gnt_idx = '0;
        any = 1'b0;
        for (int i = LANES - 1; i >= 0; i--)
            if (req[base + sel_t'(i)]) begin
                gnt_idx = base + sel_t'(i);
                any = 1'b1;
            end
        gnt = any ? (LANES'(1) << gnt_idx) : '0;
    end
endmodule

// File: rtl/mux4_1_rr.sv
// mux4_1_rr: 4-to-1 round-robin mux with lane tag and registered output; MUX4_1_RR_PRIO_EN selects fixed priority
module mux4_1_rr
    import mux4_1_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [LANES*WIDTH-1:0] DIN,
    input  logic [LANES-1:0]       VLD,
    output logic [LANES-1:0]       RDY,
    output logic [WIDTH-1:0]       DOUT,
    output sel_t                   SOUT,
    output logic                   VOUT,
    input  logic                   RIN
);
    logic [LANES-1:0] req, gnt;
    sel_t gnt_idx, ptr;
    logic any, load_en, take;
    state_t state, state_nxt;
    rr_arb4 u_arb (
        .req(req),
        .ptr(ptr),
        .gnt(gnt),
        .gnt_idx(gnt_idx),
        .any(any)
    );
    assign VOUT = state == FULL;
    assign load_en = state == EMPTY || RIN;
    assign take = load_en && any;
    always_comb begin
        req = '0;
        for (int k = 0; k < LANES; k++)
            req[k] = VLD[lane_slice(sel_t'(k))];
    end
    always_comb begin
        RDY = '0;
        for (int k = 0; k < LANES; k++)
            RDY[lane_slice(sel_t'(k))] = gnt[k] && load_en && !RST;
    end
    always_comb begin
        state_nxt = take ? FULL : (RIN ? EMPTY : state);
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= EMPTY;
        else
            state <= state_nxt;
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            DOUT <= '0;
            SOUT <= '0;
        end else if (take) begin
            DOUT <= DIN[lane_slice(gnt_idx)*WIDTH +: WIDTH];
            SOUT <= gnt_idx;
        end
    end
`ifdef MUX4_1_RR_PRIO_EN
    assign ptr = '0;
`else
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            ptr <= '0;
        else if (take)
            ptr <= gnt_idx + sel_t'(1);
    end
`endif
endmodule
